// File: rtl/unified_mem_arbiter.sv
// Arbiter that shares one single-port memory between instruction-fetch and data ports.
// Optional ROUND_ROBIN_EN: alternate the winner on simultaneous requests instead of data-first.
module unified_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    state_t     state;
    state_t     state_n;
    logic [3:0] cnt;
    logic       sel_data;
    logic       take;
    logic       take_data;
    logic       last_cycle;
    logic       data_first;

`ifdef ROUND_ROBIN_EN
    logic last_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_data <= 1'b0;
        end else if (take) begin
            last_data <= take_data;
        end
    end

    always_comb begin
        data_first = !last_data;
    end
`else
    always_comb begin
        data_first = 1'b1;
    end
`endif

    always_comb begin
        state_n    = state;
        take       = 1'b0;
        take_data  = d_req && (!if_req || data_first);
        last_cycle = (cnt == LAST_CNT);
        case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    take    = 1'b1;
                    state_n = ACCESS;
                end
            end
            ACCESS: begin
                if (last_cycle) begin
                    state_n = RESP;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // The mem_* registers double as the latched request; they are cleared on the
    // same edge that samples mem_rdata, so mem_we still identifies a write there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            sel_data  <= 1'b0;
            if_gnt    <= 1'b0;
            if_valid  <= 1'b0;
            if_rdata  <= '0;
            d_gnt     <= 1'b0;
            d_valid   <= 1'b0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            state    <= state_n;
            busy     <= (state_n != IDLE);
            if_gnt   <= 1'b0;
            d_gnt    <= 1'b0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            if (take) begin
                sel_data  <= take_data;
                cnt       <= '0;
                if_gnt    <= !take_data;
                d_gnt     <= take_data;
                mem_en    <= 1'b1;
                mem_we    <= take_data && d_we;
                mem_addr  <= take_data ? d_addr : if_addr;
                mem_wdata <= take_data ? d_wdata : '0;
            end else if (state == ACCESS) begin
                if (last_cycle) begin
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    if (sel_data) begin
                        d_valid <= 1'b1;
                        if (!mem_we) begin
                            d_rdata <= mem_rdata;
                        end
                    end else begin
                        if_valid <= 1'b1;
                        if_rdata <= mem_rdata;
                    end
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

endmodule
